// File: rtl/store_merge_unit.sv
// Store merge unit: turns SB/SH/SW requests into aligned word accesses
// (read-modify-write for sub-word stores). Optional macro BYTE_ENABLE_EN.
module store_merge_unit #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_bhw,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
`ifdef BYTE_ENABLE_EN
  output logic [3:0]        mem_be,
`endif
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t           state, state_next;
  logic [CNT_W-1:0] ack_cnt;
  logic             bad_req;
  logic             timeout_hit;
  logic             accept;

  assign accept      = (state == IDLE) && req_valid;
  assign bad_req     = (req_bhw == 2'd3) ||
                       ((req_bhw == 2'd1) && req_addr[0]) ||
                       ((req_bhw == 2'd2) && (req_addr[1:0] != 2'b00));
  assign timeout_hit = (ACK_TIMEOUT != 0) && (ack_cnt == CNT_LAST);

  assign req_ready = (state == IDLE);
  assign mem_rd    = (state == READ);
  assign mem_wr    = (state == WRITE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_req)
            state_next = ERR;
`ifdef BYTE_ENABLE_EN
          else
            state_next = WRITE;
`else
          else if (req_bhw == 2'd2)
            state_next = WRITE;
          else
            state_next = READ;
`endif
        end
      end
      READ: begin
        if (mem_ack)          state_next = WRITE;
        else if (timeout_hit) state_next = ERR;
      end
      WRITE: begin
        if (mem_ack)          state_next = DONE;
        else if (timeout_hit) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef BYTE_ENABLE_EN
  logic [3:0] be_q;

  assign mem_be = (state == WRITE) ? be_q : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      be_q      <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        ack_cnt <= '0;
      else if ((state == READ) || (state == WRITE))
        ack_cnt <= ack_cnt + 1'b1;
      if (accept) begin
        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        case (req_bhw)
          2'd0: begin
            mem_wdata <= {4{req_wdata[7:0]}};
            be_q      <= 4'b0001 << req_addr[1:0];
          end
          2'd1: begin
            mem_wdata <= {2{req_wdata[15:0]}};
            be_q      <= 4'b0011 << {req_addr[1], 1'b0};
          end
          default: begin
            mem_wdata <= req_wdata;
            be_q      <= 4'b1111;
          end
        endcase
      end
    end
  end
`else
  logic [1:0]  lat_lane;
  logic        lat_half;
  logic [15:0] lat_wdata;
  logic [31:0] merged;

  // Little-endian lane insert into the word just read back.
  always_comb begin
    merged = mem_rdata;
    if (lat_half)
      merged[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
    else
      merged[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_lane  <= '0;
      lat_half  <= 1'b0;
      lat_wdata <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        ack_cnt <= '0;
      else if ((state == READ) || (state == WRITE))
        ack_cnt <= ack_cnt + 1'b1;
      if (accept) begin
        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= req_wdata;
        lat_lane  <= req_addr[1:0];
        lat_half  <= (req_bhw == 2'd1);
        lat_wdata <= req_wdata[15:0];
      end
      // Sub-word stores replace mem_wdata with the merged word on the read ack.
      if ((state == READ) && mem_ack)
        mem_wdata <= merged;
    end
  end
`endif

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
Store-side counterpart to the load data modifier: sits between the MEM stage and data memory and performs SB/SH/SW.
- Byte and halfword stores run as a read-modify-write. The unit reads the aligned word, merges the new lane in little-endian order (lane 0 = bits 7:0), then writes the word back.
- Word stores are written directly.
- Misaligned or illegal requests are rejected with an error pulse and no memory access.

Parameters:
ADDR_W, 32, byte-address width.
ACK_TIMEOUT, 16, maximum cycles to wait for mem_ack in any memory state before aborting; 0 disables the timeout.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  store request valid.
req_ready  output  1  unit can accept a request; high iff state is IDLE.
req_addr  input  ADDR_W  byte address of the store.
req_wdata  input  32  store data, right-justified (byte in 7:0, half in 15:0).
req_bhw  input  2  size: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
done  output  1  one-cycle pulse when a store completes.
err  output  1  one-cycle pulse on misalignment, illegal size or timeout.
mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}.
mem_rd  output  1  memory read request; held until acknowledged.
mem_wr  output  1  memory write request; held until acknowledged.
mem_wdata  output  32  merged write data.
mem_rdata  input  32  read data, valid in the cycle mem_ack is high during READ.
mem_ack  input  1  memory acknowledge for the current mem_rd or mem_wr.

Behaviour:
Clocking and reset:
- One clock (clk); reset rst_n is asynchronous and active-low.
- Reset forces state to IDLE and clears done, err, mem_rd, mem_wr, mem_addr, mem_wdata, the latched request and the timeout counter.
- req_ready is decoded from state, so it is 1 during and after reset.

States: IDLE, READ, WRITE, DONE, ERR.

IDLE:
- A request is accepted on the edge where req_valid && req_ready; addr, wdata and bhw are latched on that edge.
- Misaligned or illegal requests go to ERR. These are: half with addr[0]=1; word with addr[1:0]!=0; bhw=3.
- Word stores go to WRITE with mem_wdata = wdata.
- Byte and half stores go to READ.

READ:
- mem_rd=1 and mem_addr held stable.
- On the edge where mem_ack=1, mem_rdata is captured and the next state is WRITE.

WRITE:
- mem_wr=1 and mem_wdata = merged word.
- On the edge where mem_ack=1, the next state is DONE.

Merge rules:
- Byte, lane k=addr[1:0]: bits [8k+7:8k] = wdata[7:0]; other bits come from rdata.
- Half, lane h=addr[1]: bits [16h+15:16h] = wdata[15:0]; other bits come from rdata.

DONE: done=1 for exactly one cycle, then IDLE.

ERR: err=1 for exactly one cycle, mem_rd=mem_wr=0, then IDLE.

Timeout:
- The counter clears on entry to READ or WRITE and increments each cycle without mem_ack.
- If ACK_TIMEOUT!=0 and the counter reaches ACK_TIMEOUT-1 with no ack, the next state is ERR. No write is issued after a read timeout.

Other rules:
- mem_ack in IDLE, DONE or ERR is ignored.
- mem_rd and mem_wr are never high together.

Latency with mem_ack high in the same cycle as the request (accept edge = cycle 0):
- Byte/half: READ in cycle 1, WRITE in cycle 2, done in cycle 3; next accept in cycle 4.
- Word: WRITE in cycle 1, done in cycle 2.

Reset mid-operation: mem_rd and mem_wr drop immediately (asynchronous); the in-flight store is discarded.

Optional Feature:
Macro: BYTE_ENABLE_EN.
- Defined:
  - An extra port mem_be (output, 4 bits) is present.
  - All sizes skip READ and go IDLE→WRITE directly.
  - mem_wdata carries the data replicated across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}.
  - mem_be is 4'b0001<<addr[1:0] for byte, 4'b0011<<{addr[1],1'b0} for half, 4'b1111 for word, and 0 outside WRITE.
  - Byte/half latency becomes 2 cycles.
- Undefined: no mem_be port; read-modify-write as described above.

Test Plan:
1. SB addr=0x1001, wdata=0x00000077, mem_rdata=0xAABBCCDD, zero-wait ack -> mem_rd at 0x1000 in cycle 1, mem_wr with mem_wdata=0xAABB77DD in cycle 2, done in cycle 3, err=0.
2. SH addr=0x2002, wdata=0x00001234, mem_rdata=0xAABBCCDD, ack delayed 3 cycles per access -> mem_wdata=0x1234CCDD; mem_rd held 4 cycles then mem_wr held 4 cycles; one done pulse.
3. SW addr=0x3000, wdata=0xDEADBEEF -> no mem_rd; mem_wr in cycle 1 with 0xDEADBEEF at 0x3000; done in cycle 2.
4. SH addr=0x2001, then SW addr=0x3002, then bhw=3 -> each gives err for one cycle after accept, mem_rd=mem_wr=0 throughout, req_ready back high after ERR.
5. SB with mem_ack held 0, ACK_TIMEOUT=16 -> mem_rd high for 16 cycles, then err pulse; mem_wr never asserted.
6. rst_n low while in WRITE -> mem_wr, done and err go to 0 without a clock edge; after release req_ready=1 and the next SW completes normally. With BYTE_ENABLE_EN defined, SB addr=0x1003 -> mem_be=4'b1000, mem_wdata=0x77777777, no mem_rd.
